// File: rtl/ring_ctrl.sv
// Alarm / hourly-chime sequencer producing the 2-bit ring code for the buzzer driver.
// Optional snooze support is compiled in when the macro RING_SNOOZE_EN is defined.
module ring_ctrl #(
  parameter int CHIME_SECS  = 5,
  parameter int ALARM_SECS  = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_min,
  input  logic       alarm_en,
  input  logic       stop,
`ifdef RING_SNOOZE_EN
  input  logic       snooze,
`endif
  output logic [1:0] ring,
  output logic       alarm_active,
  output logic       chime_active
);

  localparam int MAX_AC   = (ALARM_SECS > CHIME_SECS) ? ALARM_SECS : CHIME_SECS;
  localparam int MAX_SECS = (SNOOZE_SECS > MAX_AC) ? SNOOZE_SECS : MAX_AC;
  localparam int CNT_W    = $clog2(MAX_SECS) + 1;

  localparam logic [CNT_W-1:0] ALARM_LOAD  = CNT_W'(ALARM_SECS - 1);
  localparam logic [CNT_W-1:0] CHIME_LOAD  = CNT_W'(CHIME_SECS - 1);
`ifdef RING_SNOOZE_EN
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SECS - 1);
`endif

  localparam logic [1:0] RING_OFF  = 2'b00;
  localparam logic [1:0] RING_SLOW = 2'b01;
  localparam logic [1:0] RING_FAST = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHIME = 2'd1,
    ALARM = 2'd2
`ifdef RING_SNOOZE_EN
    , SNOOZE = 2'd3
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             stop_q;
  logic             stop_rise;
  logic             alarm_hit;
  logic             chime_hit;
  logic             cnt_zero;
  logic [1:0]       ring_nxt;
  logic             alarm_active_nxt;
  logic             chime_active_nxt;
`ifdef RING_SNOOZE_EN
  logic             snooze_q;
  logic             snooze_rise;
`endif

  assign stop_rise = stop & ~stop_q;
`ifdef RING_SNOOZE_EN
  assign snooze_rise = snooze & ~snooze_q;
`endif

  // Time inputs only matter in tick cycles, so both hits are qualified by the tick.
  assign alarm_hit = tick_1hz && alarm_en && (hour == alarm_hour) &&
                     (minute == alarm_min) && (second == 8'h00);
  assign chime_hit = tick_1hz && (minute == 8'h59) && (second == 8'h55);
  assign cnt_zero  = (cnt == '0);

  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (alarm_hit) begin
          state_nxt = ALARM;
          cnt_nxt   = ALARM_LOAD;
        end else if (chime_hit) begin
          state_nxt = CHIME;
          cnt_nxt   = CHIME_LOAD;
        end
      end
      CHIME: begin
        // A stop press coinciding with the alarm minute must not swallow the alarm.
        if (alarm_hit) begin
          state_nxt = ALARM;
          cnt_nxt   = ALARM_LOAD;
        end else if (stop_rise) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (tick_1hz) begin
          if (cnt_zero) state_nxt = IDLE;
          else          cnt_nxt   = cnt - 1'b1;
        end
      end
      ALARM: begin
        if (!alarm_en || stop_rise) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
`ifdef RING_SNOOZE_EN
        end else if (snooze_rise) begin
          state_nxt = SNOOZE;
          cnt_nxt   = SNOOZE_LOAD;
`endif
        end else if (tick_1hz) begin
          if (cnt_zero) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
      end
`ifdef RING_SNOOZE_EN
      SNOOZE: begin
        if (!alarm_en || stop_rise) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (alarm_hit) begin
          state_nxt = ALARM;
          cnt_nxt   = ALARM_LOAD;
        end else if (tick_1hz) begin
          if (cnt_zero) begin
            state_nxt = ALARM;
            cnt_nxt   = ALARM_LOAD;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    ring_nxt         = RING_OFF;
    alarm_active_nxt = 1'b0;
    chime_active_nxt = 1'b0;
    unique case (state_nxt)
      CHIME: begin
        ring_nxt         = RING_SLOW;
        chime_active_nxt = 1'b1;
      end
      ALARM: begin
        ring_nxt         = RING_FAST;
        alarm_active_nxt = 1'b1;
      end
`ifdef RING_SNOOZE_EN
      SNOOZE: alarm_active_nxt = 1'b1;
`endif
      default: ring_nxt = RING_OFF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      stop_q       <= 1'b0;
      ring         <= RING_OFF;
      alarm_active <= 1'b0;
      chime_active <= 1'b0;
`ifdef RING_SNOOZE_EN
      snooze_q     <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      stop_q       <= stop;
      ring         <= ring_nxt;
      alarm_active <= alarm_active_nxt;
      chime_active <= chime_active_nxt;
`ifdef RING_SNOOZE_EN
      snooze_q     <= snooze;
`endif
    end
  end

endmodule

// File: tb/tb_ring_ctrl.sv
// Directed scoreboard bench for ring_ctrl (ALARM_SECS=3, CHIME_SECS=5, SNOOZE_SECS=2).
// Snooze steps run only when RING_SNOOZE_EN is defined.
module tb_ring_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz;
  logic [7:0] hour, minute, second;
  logic [7:0] alarm_hour, alarm_min;
  logic       alarm_en;
  logic       stop;
`ifdef RING_SNOOZE_EN
  logic       snooze;
`endif
  logic [1:0] ring;
  logic       alarm_active;
  logic       chime_active;

  typedef struct {
    string      tag;
    logic [1:0] ring;
    logic       aa;
    logic       ca;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ring_ctrl #(
    .CHIME_SECS (5),
    .ALARM_SECS (3),
    .SNOOZE_SECS(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_1hz    (tick_1hz),
    .hour        (hour),
    .minute      (minute),
    .second      (second),
    .alarm_hour  (alarm_hour),
    .alarm_min   (alarm_min),
    .alarm_en    (alarm_en),
    .stop        (stop),
`ifdef RING_SNOOZE_EN
    .snooze      (snooze),
`endif
    .ring        (ring),
    .alarm_active(alarm_active),
    .chime_active(chime_active)
  );

  task automatic push_exp(input string tag, input logic [1:0] r, input logic aa);
    exp_t e;
    e.tag  = tag;
    e.ring = r;
    e.aa   = aa;
    e.ca   = (r == 2'b01);
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    e = sb.pop_front();
    vectors++;
    assert (ring === e.ring && alarm_active === e.aa && chime_active === e.ca)
    else begin
      miscompares++;
      $error("FAIL %s: got ring=%b alarm_active=%b chime_active=%b, expected ring=%b alarm_active=%b chime_active=%b",
             e.tag, ring, alarm_active, chime_active, e.ring, e.aa, e.ca);
    end
  endtask

  // One clock with current inputs, then check outputs 1 time unit after the edge.
  task automatic cycle(input string tag, input logic [1:0] r, input logic aa);
    push_exp(tag, r, aa);
    @(posedge clk);
    #1;
    compare();
  endtask

  // One second: a tick cycle at h:m:s followed by a quiet cycle that must hold the result.
  task automatic sec(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                     input logic [1:0] r, input logic aa, input string tag);
    hour     = h;
    minute   = m;
    second   = s;
    tick_1hz = 1'b1;
    cycle(tag, r, aa);
    tick_1hz = 1'b0;
    cycle({tag, "_hold"}, r, aa);
  endtask

  initial begin
    rst_n      = 1'b0;
    tick_1hz   = 1'b0;
    hour       = 8'h00;
    minute     = 8'h00;
    second     = 8'h00;
    alarm_hour = 8'h00;
    alarm_min  = 8'h00;
    alarm_en   = 1'b0;
    stop       = 1'b0;
`ifdef RING_SNOOZE_EN
    snooze     = 1'b0;
`endif
    #12;
    push_exp("reset", 2'b00, 1'b0);
    compare();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Hourly chime: ring=01 for ticks 59:55..59:59, silent after 13:00:00.
    sec(8'h12, 8'h59, 8'h54, 2'b00, 1'b0, "pre_chime");
    sec(8'h12, 8'h59, 8'h55, 2'b01, 1'b0, "chime_55");
    sec(8'h12, 8'h59, 8'h56, 2'b01, 1'b0, "chime_56");
    sec(8'h12, 8'h59, 8'h57, 2'b01, 1'b0, "chime_57");
    sec(8'h12, 8'h59, 8'h58, 2'b01, 1'b0, "chime_58");
    sec(8'h12, 8'h59, 8'h59, 2'b01, 1'b0, "chime_59");
    sec(8'h13, 8'h00, 8'h00, 2'b00, 1'b0, "chime_end");
    sec(8'h13, 8'h00, 8'h01, 2'b00, 1'b0, "post_chime");

    // Alarm timeout with ALARM_SECS=3; matching time without a tick is ignored.
    alarm_hour = 8'h07;
    alarm_min  = 8'h30;
    alarm_en   = 1'b1;
    hour       = 8'h07;
    minute     = 8'h30;
    second     = 8'h00;
    cycle("no_tick_match", 2'b00, 1'b0);
    sec(8'h07, 8'h29, 8'h59, 2'b00, 1'b0, "pre_alarm");
    sec(8'h07, 8'h30, 8'h00, 2'b10, 1'b1, "alarm_start");
    sec(8'h07, 8'h30, 8'h01, 2'b10, 1'b1, "alarm_01");
    sec(8'h07, 8'h30, 8'h02, 2'b10, 1'b1, "alarm_02");
    sec(8'h07, 8'h30, 8'h03, 2'b00, 1'b0, "alarm_timeout");

    // Stop edge silences; a held stop does not affect the next alarm.
    alarm_min = 8'h31;
    sec(8'h07, 8'h31, 8'h00, 2'b10, 1'b1, "alarm31");
    stop = 1'b1;
    cycle("stop_rise", 2'b00, 1'b0);
    alarm_min = 8'h32;
    sec(8'h07, 8'h32, 8'h00, 2'b10, 1'b1, "held_stop_alarm");
    sec(8'h07, 8'h32, 8'h01, 2'b10, 1'b1, "held_stop_tick");
    stop = 1'b0;
    cycle("stop_release", 2'b10, 1'b1);
    alarm_en = 1'b0;
    cycle("disarm", 2'b00, 1'b0);

    // Stop rising in the same tick as the alarm hit: alarm wins.
    alarm_en  = 1'b1;
    alarm_min = 8'h33;
    stop      = 1'b1;
    sec(8'h07, 8'h33, 8'h00, 2'b10, 1'b1, "stop_vs_hit");
    stop = 1'b0;
    sec(8'h07, 8'h33, 8'h01, 2'b10, 1'b1, "stop_vs_hit_01");
    sec(8'h07, 8'h33, 8'h02, 2'b10, 1'b1, "stop_vs_hit_02");
    sec(8'h07, 8'h33, 8'h03, 2'b00, 1'b0, "stop_vs_hit_end");
    alarm_en  = 1'b0;
    alarm_min = 8'h34;
    sec(8'h07, 8'h34, 8'h00, 2'b00, 1'b0, "disarmed_match");

    // Alarm at 09:00 pre-empts the chime directly from 01 to 10.
    alarm_hour = 8'h09;
    alarm_min  = 8'h00;
    alarm_en   = 1'b1;
    sec(8'h08, 8'h59, 8'h55, 2'b01, 1'b0, "pre_chime_55");
    sec(8'h08, 8'h59, 8'h56, 2'b01, 1'b0, "pre_chime_56");
    sec(8'h08, 8'h59, 8'h57, 2'b01, 1'b0, "pre_chime_57");
    sec(8'h08, 8'h59, 8'h58, 2'b01, 1'b0, "pre_chime_58");
    sec(8'h08, 8'h59, 8'h59, 2'b01, 1'b0, "pre_chime_59");
    sec(8'h09, 8'h00, 8'h00, 2'b10, 1'b1, "preempt");
    sec(8'h09, 8'h00, 8'h01, 2'b10, 1'b1, "preempt_01");
    sec(8'h09, 8'h00, 8'h02, 2'b10, 1'b1, "preempt_02");
    sec(8'h09, 8'h00, 8'h03, 2'b00, 1'b0, "preempt_end");

    // Stop during a chime.
    alarm_en = 1'b0;
    sec(8'h10, 8'h59, 8'h55, 2'b01, 1'b0, "chime2");
    stop = 1'b1;
    cycle("chime_stop", 2'b00, 1'b0);
    stop = 1'b0;
    sec(8'h10, 8'h59, 8'h56, 2'b00, 1'b0, "chime_stopped");

    // Asynchronous reset mid-alarm clears outputs without a clock edge.
    alarm_en   = 1'b1;
    alarm_hour = 8'h11;
    alarm_min  = 8'h15;
    sec(8'h11, 8'h15, 8'h00, 2'b10, 1'b1, "alarm_pre_reset");
    rst_n = 1'b0;
    #2;
    push_exp("async_reset", 2'b00, 1'b0);
    compare();
    #1;
    rst_n = 1'b1;
    sec(8'h11, 8'h15, 8'h01, 2'b00, 1'b0, "after_reset");
    sec(8'h11, 8'h15, 8'h02, 2'b00, 1'b0, "after_reset_2");

`ifdef RING_SNOOZE_EN
    // Snooze: silent but alarm_active for 2 seconds, then fast ring again; stop+snooze ends.
    alarm_hour = 8'h06;
    alarm_min  = 8'h00;
    sec(8'h06, 8'h00, 8'h00, 2'b10, 1'b1, "snz_alarm");
    snooze = 1'b1;
    cycle("snz_enter", 2'b00, 1'b1);
    snooze = 1'b0;
    sec(8'h06, 8'h00, 8'h01, 2'b00, 1'b1, "snz_01");
    sec(8'h06, 8'h00, 8'h02, 2'b10, 1'b1, "snz_rering");
    stop   = 1'b1;
    snooze = 1'b1;
    cycle("snz_stop_both", 2'b00, 1'b0);
    stop   = 1'b0;
    snooze = 1'b0;
    sec(8'h06, 8'h00, 8'h03, 2'b00, 1'b0, "snz_idle");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
